// File: rtl/nbit_arb_mux.sv
// N-to-1 round-robin gathering mux feeding a one-entry valid/ready buffer.
// The winner's word and binary index are registered for a single consumer.
module nbit_arb_mux #(
  parameter int SELECT_WIDTH = 3,
  parameter int DATA_WIDTH   = 32,
  localparam int N = 2**SELECT_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N-1:0]            MuxReq,
  input  logic [N*DATA_WIDTH-1:0] MuxData,
  output logic [N-1:0]            MuxAck,
  output logic [DATA_WIDTH-1:0]   MuxOut,
  output logic [SELECT_WIDTH-1:0] MuxSel,
  output logic                    MuxOutValid,
  input  logic                    MuxOutReady
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [SELECT_WIDTH-1:0] ptr_q, ptr_d;
  logic [SELECT_WIDTH-1:0] sel_q, sel_d;
  logic [DATA_WIDTH-1:0]   out_q, out_d;

  logic [SELECT_WIDTH-1:0] win;
  logic [SELECT_WIDTH-1:0] idx;
  logic                    found;
  logic [DATA_WIDTH-1:0]   win_word;
  logic                    can_load;
  logic                    drain;
  logic                    cap;

  // Scan from ptr upward; SELECT_WIDTH-bit adds wrap modulo N.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = ptr_q + SELECT_WIDTH'(k);
      if (!found && MuxReq[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    win_word = '0;
    for (int j = 0; j < N; j++) begin
      if (win == SELECT_WIDTH'(j)) begin
        win_word = MuxData[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign drain    = (state_q == FULL) & MuxOutReady;
  assign can_load = (state_q == EMPTY) | MuxOutReady;
  assign cap      = can_load & found & !reset;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    out_d   = out_q;
    MuxAck  = '0;
    if (cap) begin
      MuxAck[win] = 1'b1;
      out_d       = win_word;
      sel_d       = win;
      state_d     = FULL;
      ptr_d       = win + SELECT_WIDTH'(1);
    end else if (drain) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      sel_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
    end
  end

  assign MuxOut      = out_q;
  assign MuxSel      = sel_q;
  assign MuxOutValid = (state_q == FULL);

endmodule

// File: tb/tb_nbit_arb_mux.sv
// Directed bench for nbit_arb_mux: reset, latency, round-robin order,
// backpressure, pointer fairness and mid-operation reset.
module tb_nbit_arb_mux;

  localparam int SW = 3;
  localparam int DW = 32;
  localparam int N  = 2**SW;

  logic            clk;
  logic            reset;
  logic [N-1:0]    MuxReq;
  logic [N*DW-1:0] MuxData;
  logic [N-1:0]    MuxAck;
  logic [DW-1:0]   MuxOut;
  logic [SW-1:0]   MuxSel;
  logic            MuxOutValid;
  logic            MuxOutReady;

  int checks   = 0;
  int failures = 0;

  nbit_arb_mux #(
    .SELECT_WIDTH(SW),
    .DATA_WIDTH  (DW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .MuxReq     (MuxReq),
    .MuxData    (MuxData),
    .MuxAck     (MuxAck),
    .MuxOut     (MuxOut),
    .MuxSel     (MuxSel),
    .MuxOutValid(MuxOutValid),
    .MuxOutReady(MuxOutReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    MuxReq      = '0;
    MuxData     = '0;
    MuxOutReady = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_valid", 32'(MuxOutValid), 32'd0);
    chk("rst_out", MuxOut, 32'd0);
    chk("rst_sel", 32'(MuxSel), 32'd0);
    chk("rst_ack", 32'(MuxAck), 32'd0);

    // idle
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_valid", 32'(MuxOutValid), 32'd0);
      chk("idle_ack", 32'(MuxAck), 32'd0);
    end

    // single request, index 5
    MuxData[5*DW +: DW] = 32'hA5A5_0005;
    MuxReq      = 8'h20;
    MuxOutReady = 1'b1;
    #1;
    chk("t2_ack", 32'(MuxAck), 32'h20);
    tick();
    MuxReq = '0;
    #1;
    chk("t2_valid", 32'(MuxOutValid), 32'd1);
    chk("t2_out", MuxOut, 32'hA5A5_0005);
    chk("t2_sel", 32'(MuxSel), 32'd5);
    chk("t2_ack_off", 32'(MuxAck), 32'd0);
    tick();
    chk("t2_drain", 32'(MuxOutValid), 32'd0);

    // all requests held, from reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < N; i++) MuxData[i*DW +: DW] = 32'h100 + 32'(i);
    MuxReq = '1;
    #1;
    for (int k = 0; k < 10; k++) begin
      chk("t3_ack", 32'(MuxAck), 32'(1) << (k % N));
      tick();
      chk("t3_sel", 32'(MuxSel), 32'(k % N));
      chk("t3_out", MuxOut, 32'h100 + 32'(k % N));
      chk("t3_valid", 32'(MuxOutValid), 32'd1);
    end
    MuxReq = '0;
    tick();
    chk("t3_drain", 32'(MuxOutValid), 32'd0);

    // backpressure (ptr now 2)
    MuxReq = 8'h04;
    #1;
    chk("t4_ack2", 32'(MuxAck), 32'h04);
    tick();
    MuxReq      = 8'h08;
    MuxOutReady = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk("t4_ack_hold", 32'(MuxAck), 32'd0);
      tick();
      chk("t4_sel_hold", 32'(MuxSel), 32'd2);
      chk("t4_out_hold", MuxOut, 32'h102);
      chk("t4_valid_hold", 32'(MuxOutValid), 32'd1);
    end
    MuxOutReady = 1'b1;
    #1;
    chk("t4_ack3", 32'(MuxAck), 32'h08);
    tick();
    MuxReq = '0;
    #1;
    chk("t4_sel3", 32'(MuxSel), 32'd3);
    chk("t4_valid3", 32'(MuxOutValid), 32'd1);
    tick();
    chk("t4_drain", 32'(MuxOutValid), 32'd0);

    // fairness after ptr moves (ptr now 4)
    MuxReq = 8'h40;
    #1;
    chk("t5_ack6", 32'(MuxAck), 32'h40);
    tick();
    chk("t5_sel6", 32'(MuxSel), 32'd6);
    MuxReq = 8'h82;
    #1;
    chk("t5_ack7", 32'(MuxAck), 32'h80);
    tick();
    chk("t5_sel7", 32'(MuxSel), 32'd7);
    MuxReq = 8'h02;
    #1;
    chk("t5_ack1", 32'(MuxAck), 32'h02);
    tick();
    chk("t5_sel1", 32'(MuxSel), 32'd1);
    chk("t5_out1", MuxOut, 32'h101);
    MuxReq = '0;
    tick();
    chk("t5_drain", 32'(MuxOutValid), 32'd0);

    // reset mid-operation (ptr now 2)
    MuxReq      = 8'h10;
    MuxOutReady = 1'b0;
    #1;
    chk("t6_ack4", 32'(MuxAck), 32'h10);
    tick();
    MuxReq = 8'h01;
    #1;
    chk("t6_sel4", 32'(MuxSel), 32'd4);
    chk("t6_full_ack", 32'(MuxAck), 32'd0);
    reset = 1'b1;
    #1;
    chk("t6_rst_ack", 32'(MuxAck), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("t6_valid", 32'(MuxOutValid), 32'd0);
    chk("t6_sel0", 32'(MuxSel), 32'd0);
    chk("t6_out0", MuxOut, 32'd0);
    chk("t6_ack0", 32'(MuxAck), 32'h01);
    tick();
    chk("t6_grant0", 32'(MuxSel), 32'd0);
    chk("t6_grant0_out", MuxOut, 32'h100);
    chk("t6_grant0_v", 32'(MuxOutValid), 32'd1);

    // reset masks acks even when a capture would be possible
    MuxReq      = '1;
    MuxOutReady = 1'b1;
    reset       = 1'b1;
    #1;
    chk("t6_rst_mask", 32'(MuxAck), 32'd0);
    tick();
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
